// File: rtl/nvdla_pdp_rdma_pkg.sv
// ---------------------------------------------------------------------------
// Module : nvdla_pdp_rdma_pkg
// Brief  : shared types for the PDP RDMA request generator.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nvdla_pdp_rdma_pkg;

   typedef enum logic [1:0] {
      PDP_IDLE  = 2'd0,
      PDP_REQ   = 2'd1,
      PDP_DRAIN = 2'd2,
      PDP_DONE  = 2'd3
   } pdp_state_e;

   localparam int CQ_PD_W = 7;
   localparam int LEN_W   = 4;
   localparam int DIM_W   = 13;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic             last_line;
      logic             last_surf;
      logic             last_cube;
   } cq_entry_t;

   // Counter width able to hold 0..max_outs inclusive.
   function automatic int outs_w(input int max_outs);
      return (max_outs < 1) ? 1 : $clog2(max_outs + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nvdla_pdp_rdma_outs_cnt.sv
// ---------------------------------------------------------------------------
// Module : nvdla_pdp_rdma_outs_cnt
// Brief  : outstanding-request tracker, saturating at zero on stray decrements.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nvdla_pdp_rdma_outs_cnt
   import nvdla_pdp_rdma_pkg::*;
#(
   parameter int MAX_OUTS = 16
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          inc,
   input  logic                          dec,
   output logic [outs_w(MAX_OUTS)-1:0]   cnt,
   output logic                          full,
   output logic                          empty
);

   localparam int CW = outs_w(MAX_OUTS);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTS);

   logic [CW-1:0] r_cnt;
   logic          w_dec_ok;

   // A response with nothing outstanding is dropped rather than wrapping.
   assign w_dec_ok = dec && (r_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (inc && !w_dec_ok) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (!inc && w_dec_ok) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign cnt   = r_cnt;
   assign full  = (r_cnt >= MAX_CNT);
   assign empty = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/nvdla_pdp_rdma_reqgen.sv
// ---------------------------------------------------------------------------
// Module : nvdla_pdp_rdma_reqgen
// Brief  : walks a cube atom/line/surface and issues burst read requests.
//          Define NVDLA_PDP_RDMA_PERF_EN to build the read-stall counter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nvdla_pdp_rdma_reqgen
   import nvdla_pdp_rdma_pkg::*;
#(
   parameter int AW         = 64,
   parameter int BURST_MAX  = 8,
   parameter int MAX_OUTS   = 16,
   parameter int ATOM_BYTES = 32
)(
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rst,
   input  logic                 op_en,
   input  logic [AW-1:0]        cfg_base_addr,
   input  logic [31:0]          cfg_line_stride,
   input  logic [31:0]          cfg_surf_stride,
   input  logic [DIM_W-1:0]     cfg_width,
   input  logic [DIM_W-1:0]     cfg_height,
   input  logic [DIM_W-1:0]     cfg_surfaces,
   output logic                 req_valid,
   input  logic                 req_ready,
   output logic [AW-1:0]        req_addr,
   output logic [LEN_W-1:0]     req_len,
   input  logic                 cq_ready,
   output logic                 cq_valid,
   output logic [CQ_PD_W-1:0]   cq_pd,
   input  logic                 rsp_done,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          perf_read_stall
);

   localparam int OW = outs_w(MAX_OUTS);

   localparam logic [1:0] ST_IDLE  = PDP_IDLE;
   localparam logic [1:0] ST_REQ   = PDP_REQ;
   localparam logic [1:0] ST_DRAIN = PDP_DRAIN;
   localparam logic [1:0] ST_DONE  = PDP_DONE;

   localparam logic [DIM_W:0]   BURST_ATOMS = (DIM_W+1)'(BURST_MAX);
   localparam logic [DIM_W-1:0] BURST_STEP  = DIM_W'(BURST_MAX);
   localparam logic [LEN_W-1:0] BURST_LEN   = LEN_W'(BURST_MAX - 1);
   localparam logic [AW-1:0]    BURST_BYTES = AW'(BURST_MAX * ATOM_BYTES);

   logic [1:0]        r_state;

   logic [AW-1:0]     r_line_stride;
   logic [AW-1:0]     r_surf_stride;
   logic [DIM_W-1:0]  r_width;
   logic [DIM_W-1:0]  r_height;
   logic [DIM_W-1:0]  r_surfaces;

   logic [DIM_W-1:0]  r_atom;
   logic [DIM_W-1:0]  r_line;
   logic [DIM_W-1:0]  r_surf;
   logic [AW-1:0]     r_surf_base;
   logic [AW-1:0]     r_line_base;
   logic [AW-1:0]     r_addr;

   logic [DIM_W:0]    w_rem;
   logic              w_last_line;
   logic              w_last_surf;
   logic              w_last_cube;
   logic [LEN_W-1:0]  w_len;
   logic              w_issue;
   logic [AW-1:0]     w_next_line_base;
   logic [AW-1:0]     w_next_surf_base;
   cq_entry_t         w_entry;

   logic [OW-1:0]     w_outs;
   logic              w_full;
   logic              w_empty;
   logic              w_drain_zero;

   // Atoms left in the current line, always >= 1 while requesting.
   assign w_rem       = {1'b0, r_width} + 1'b1 - {1'b0, r_atom};
   assign w_last_line = (w_rem <= BURST_ATOMS);
   assign w_last_surf = w_last_line && (r_line == r_height);
   assign w_last_cube = w_last_surf && (r_surf == r_surfaces);
   assign w_len       = w_last_line ? (w_rem[LEN_W-1:0] - 1'b1) : BURST_LEN;

   assign w_next_line_base = r_line_base + r_line_stride;
   assign w_next_surf_base = r_surf_base + r_surf_stride;

   assign req_valid = (r_state == ST_REQ) && cq_ready && !w_full;
   assign w_issue   = req_valid && req_ready;
   assign req_addr  = r_addr;
   assign req_len   = w_len;

   assign w_entry.len       = w_len;
   assign w_entry.last_line = w_last_line;
   assign w_entry.last_surf = w_last_surf;
   assign w_entry.last_cube = w_last_cube;

   assign cq_valid = w_issue;
   assign cq_pd    = w_issue ? w_entry : '0;

   assign busy = (r_state != ST_IDLE);
   assign done = (r_state == ST_DONE);

   nvdla_pdp_rdma_outs_cnt #(
      .MAX_OUTS (MAX_OUTS)
   ) u_outs (
      .clk   (nvdla_core_clk),
      .rst   (nvdla_core_rst),
      .inc   (w_issue),
      .dec   (rsp_done),
      .cnt   (w_outs),
      .full  (w_full),
      .empty (w_empty)
   );

   // Leave DRAIN in the same cycle the last response retires.
   assign w_drain_zero = w_empty || ((w_outs == OW'(1)) && rsp_done);

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_state       <= ST_IDLE;
         r_line_stride <= '0;
         r_surf_stride <= '0;
         r_width       <= '0;
         r_height      <= '0;
         r_surfaces    <= '0;
         r_atom        <= '0;
         r_line        <= '0;
         r_surf        <= '0;
         r_surf_base   <= '0;
         r_line_base   <= '0;
         r_addr        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (op_en) begin
                  r_state       <= ST_REQ;
                  r_line_stride <= AW'(cfg_line_stride);
                  r_surf_stride <= AW'(cfg_surf_stride);
                  r_width       <= cfg_width;
                  r_height      <= cfg_height;
                  r_surfaces    <= cfg_surfaces;
                  r_atom        <= '0;
                  r_line        <= '0;
                  r_surf        <= '0;
                  r_surf_base   <= cfg_base_addr;
                  r_line_base   <= cfg_base_addr;
                  r_addr        <= cfg_base_addr;
               end
            end
            ST_REQ: begin
               if (w_issue) begin
                  if (!w_last_line) begin
                     r_atom <= r_atom + BURST_STEP;
                     r_addr <= r_addr + BURST_BYTES;
                  end else if (!w_last_surf) begin
                     r_atom      <= '0;
                     r_line      <= r_line + 1'b1;
                     r_line_base <= w_next_line_base;
                     r_addr      <= w_next_line_base;
                  end else if (!w_last_cube) begin
                     r_atom      <= '0;
                     r_line      <= '0;
                     r_surf      <= r_surf + 1'b1;
                     r_surf_base <= w_next_surf_base;
                     r_line_base <= w_next_surf_base;
                     r_addr      <= w_next_surf_base;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_drain_zero) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef NVDLA_PDP_RDMA_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         r_perf <= '0;
      end else if ((r_state == ST_IDLE) && op_en) begin
         r_perf <= '0;
      end else if (req_valid && !req_ready && (r_perf != 32'hFFFF_FFFF)) begin
         r_perf <= r_perf + 1'b1;
      end
   end

   assign perf_read_stall = r_perf;
`else
   assign perf_read_stall = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nvdla_pdp_rdma_reqgen.sv
// ---------------------------------------------------------------------------
// Module : tb_nvdla_pdp_rdma_reqgen
// Brief  : self-checking bench for nvdla_pdp_rdma_reqgen against a cube-walk model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nvdla_pdp_rdma_reqgen;

   localparam int BURST = 8;
   localparam int ATOM  = 32;
   localparam int MAXO  = 16;
   localparam int RUN_BUDGET = 4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_en = 1'b0;
   logic        op_en2 = 1'b0;
   logic [63:0] cfg_base_addr = '0;
   logic [31:0] cfg_line_stride = '0;
   logic [31:0] cfg_surf_stride = '0;
   logic [12:0] cfg_width = '0;
   logic [12:0] cfg_height = '0;
   logic [12:0] cfg_surfaces = '0;
   logic        req_ready = 1'b0;
   logic        req_ready2 = 1'b0;
   logic        cq_ready = 1'b0;
   logic        rsp_done = 1'b0;
   logic        rsp_done2 = 1'b0;

   logic        req_valid, cq_valid, busy, done;
   logic [63:0] req_addr;
   logic [3:0]  req_len;
   logic [6:0]  cq_pd;
   logic [31:0] perf_read_stall;

   logic        req_valid2, cq_valid2, busy2, done2;
   logic [63:0] req_addr2;
   logic [3:0]  req_len2;
   logic [6:0]  cq_pd2;
   logic [31:0] perf_read_stall2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nvdla_pdp_rdma_reqgen #(
      .AW(64), .BURST_MAX(BURST), .MAX_OUTS(MAXO), .ATOM_BYTES(ATOM)
   ) dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_en(op_en),
      .cfg_base_addr(cfg_base_addr), .cfg_line_stride(cfg_line_stride),
      .cfg_surf_stride(cfg_surf_stride), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .cfg_surfaces(cfg_surfaces),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .cq_ready(cq_ready), .cq_valid(cq_valid), .cq_pd(cq_pd),
      .rsp_done(rsp_done), .busy(busy), .done(done), .perf_read_stall(perf_read_stall)
   );

   nvdla_pdp_rdma_reqgen #(
      .AW(64), .BURST_MAX(BURST), .MAX_OUTS(2), .ATOM_BYTES(ATOM)
   ) dut2 (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_en(op_en2),
      .cfg_base_addr(cfg_base_addr), .cfg_line_stride(cfg_line_stride),
      .cfg_surf_stride(cfg_surf_stride), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .cfg_surfaces(cfg_surfaces),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2), .req_len(req_len2),
      .cq_ready(cq_ready), .cq_valid(cq_valid2), .cq_pd(cq_pd2),
      .rsp_done(rsp_done2), .busy(busy2), .done(done2), .perf_read_stall(perf_read_stall2)
   );

   typedef struct {
      logic [63:0] addr;
      logic [3:0]  len;
      logic        ll;
      logic        ls;
      logic        lc;
   } req_t;

   typedef struct {
      logic [63:0] base;
      logic [12:0] w;
      logic [12:0] h;
      logic [12:0] s;
      logic [31:0] lstr;
      logic [31:0] sstr;
      int          exp_n;
      logic [63:0] exp_last_addr;
      logic [3:0]  exp_last_len;
   } tvec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      op_en = 1'b0; op_en2 = 1'b0;
      rsp_done = 1'b0; rsp_done2 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Expected requests come from nested loops over surface/line/atom with plain
   // multiplication; handshakes and the phase sequence are checked every cycle.
   task automatic run_cfg(input logic [63:0] base, input logic [12:0] w, input logic [12:0] h,
                          input logic [12:0] s, input logic [31:0] lstr, input logic [31:0] sstr,
                          input bit rnd, input int stall_first,
                          output int n_iss, output logic [63:0] last_addr,
                          output logic [3:0] last_len, output int n_done, output int stalls);
      req_t q[$];
      req_t e;
      int   phase;
      int   outs;
      int   cyc;
      bit   iss;
      bit   dec;
      bit   last_seen;
      for (int si = 0; si <= int'(s); si++) begin
         for (int li = 0; li <= int'(h); li++) begin
            for (int a = 0; a <= int'(w); a += BURST) begin
               int n;
               n = (int'(w) + 1 - a > BURST) ? BURST : int'(w) + 1 - a;
               e.addr = base + 64'(si) * 64'(sstr) + 64'(li) * 64'(lstr) + 64'(a) * 64'(ATOM);
               e.len  = 4'(n - 1);
               e.ll   = (a + n == int'(w) + 1);
               e.ls   = e.ll && (li == int'(h));
               e.lc   = e.ls && (si == int'(s));
               q.push_back(e);
            end
         end
      end
      n_iss = 0; n_done = 0; stalls = 0; last_addr = '0; last_len = '0;
      phase = 0; outs = 0; cyc = 0;
      while (cyc < RUN_BUDGET) begin
         @(posedge clk); #1;
         if (cyc == 0) begin
            cfg_base_addr = base; cfg_width = w; cfg_height = h; cfg_surfaces = s;
            cfg_line_stride = lstr; cfg_surf_stride = sstr;
            op_en = 1'b1;
         end else begin
            // Shadowed config must ignore later changes and stray op_en pulses.
            cfg_base_addr = ~base; cfg_width = ~w; cfg_line_stride = ~lstr;
            op_en = rnd && ($urandom_range(0, 15) == 0);
         end
         cq_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         req_ready = (cyc <= stall_first) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
         rsp_done  = rnd ? ($urandom_range(0, 2) == 0) : (outs > 0);
         #1;
         chk("req_valid", req_valid, (phase == 1) && cq_ready && (outs < MAXO));
         chk("busy", busy, phase != 0);
         chk("done", done, phase == 3);
         iss = req_valid && req_ready;
         chk("cq_valid", cq_valid, iss);
         if (req_valid) begin
            if (q.size() == 0) begin
               chk("extra_request", 1, 0);
            end else begin
               chk("req_addr", req_addr, q[0].addr);
               chk("req_len", req_len, q[0].len);
            end
         end
         last_seen = 1'b0;
         if (iss && q.size() > 0) begin
            e = q.pop_front();
            chk("cq_pd", cq_pd, {e.len, e.ll, e.ls, e.lc});
            n_iss++;
            last_addr = e.addr;
            last_len  = e.len;
            last_seen = e.lc;
         end
         if (req_valid && !req_ready) stalls++;
         if (done) n_done++;
         dec  = rsp_done && (outs > 0);
         outs = outs + int'(iss) - int'(dec);
         case (phase)
            0: if (op_en) phase = 1;
            1: if (last_seen) phase = 2;
            2: if (outs == 0) phase = 3;
            default: phase = 0;
         endcase
         cyc++;
         if (cyc > 1 && phase == 0) break;
      end
      if (cyc >= RUN_BUDGET) begin
         chk("run_timeout", 1, 0);
         do_reset();
      end else begin
         chk("all_requests_seen", q.size(), 0);
`ifdef NVDLA_PDP_RDMA_PERF_EN
         chk("perf_read_stall", perf_read_stall, stalls);
`else
         chk("perf_read_stall", perf_read_stall, 0);
`endif
         @(posedge clk); #1;
         op_en = 1'b0; rsp_done = 1'b0; req_ready = 1'b0;
         #1;
         chk("idle_after_done", busy, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tvec_t       tv[6];
      int          n_iss, n_done, stalls, n;
      logic [63:0] la;
      logic [3:0]  ll;

      tv[0] = '{64'h1000, 13'd19, 13'd1, 13'd0, 32'h800, 32'h0, 6, 64'h1A00, 4'd3};
      tv[1] = '{64'hFFFF_FFFF_FFFF_FFE0, 13'd1, 13'd0, 13'd0, 32'h0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFE0, 4'd1};
      tv[2] = '{64'hFFFF_FFFF_FFFF_FFE0, 13'd8, 13'd0, 13'd0, 32'h0, 32'h0, 2, 64'hE0, 4'd0};
      tv[3] = '{64'h0, 13'd7, 13'd0, 13'd2, 32'h40, 32'h100, 3, 64'h200, 4'd7};
      tv[4] = '{64'h40, 13'd0, 13'd2, 13'd1, 32'h20, 32'h1000, 6, 64'h1080, 4'd0};
      tv[5] = '{64'h0, 13'd16, 13'd0, 13'd0, 32'h0, 32'h0, 3, 64'h200, 4'd0};

      // Outputs while reset is held, with cq_ready high so gating matters.
      cq_ready = 1'b1; req_ready = 1'b1; req_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", req_valid, 0);
      chk("rst_cq_valid", cq_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_perf", perf_read_stall, 0);
      chk("rst_req_addr", req_addr, 0);
      chk("rst_req_len", req_len, 0);
      chk("rst_cq_pd", cq_pd, 0);
      chk("rst_req_valid2", req_valid2, 0);
      chk("rst_busy2", busy2, 0);
      rst = 1'b0;

      // MAX_OUTS=2 throttling with no responses returning.
      cfg_base_addr = 64'h5000; cfg_width = 13'd63; cfg_height = 13'd0; cfg_surfaces = 13'd0;
      cfg_line_stride = 32'h0; cfg_surf_stride = 32'h0;
      rsp_done2 = 1'b0; op_en2 = 1'b1;
      @(posedge clk); #1;
      op_en2 = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_valid2 && req_ready2) n++;
         @(posedge clk); #1;
      end
      chk("max_outs_issues", n, 2);
      #1;
      chk("max_outs_valid_low", req_valid2, 0);
      rsp_done2 = 1'b1;
      @(posedge clk); #1;
      rsp_done2 = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req_valid2 && req_ready2) n++;
         @(posedge clk); #1;
      end
      chk("max_outs_one_more", n, 1);
      do_reset();

      for (int i = 0; i < 6; i++) begin
         run_cfg(tv[i].base, tv[i].w, tv[i].h, tv[i].s, tv[i].lstr, tv[i].sstr,
                 1'b0, 0, n_iss, la, ll, n_done, stalls);
         chk($sformatf("tv%0d_count", i), n_iss, tv[i].exp_n);
         chk($sformatf("tv%0d_last_addr", i), la, tv[i].exp_last_addr);
         chk($sformatf("tv%0d_last_len", i), ll, tv[i].exp_last_len);
         chk($sformatf("tv%0d_done_pulses", i), n_done, 1);
      end

      // Five cycles of back-pressure on the first request.
      run_cfg(64'h2000, 13'd19, 13'd0, 13'd0, 32'h0, 32'h0, 1'b0, 5, n_iss, la, ll, n_done, stalls);
      chk("stall_count_seen", stalls, 5);
`ifdef NVDLA_PDP_RDMA_PERF_EN
      chk("perf_stall5", perf_read_stall, 5);
`else
      chk("perf_stall5", perf_read_stall, 0);
`endif

      // Issue coinciding with a response at one outstanding, then final response.
      @(posedge clk); #1;
      cfg_base_addr = 64'h100; cfg_width = 13'd15; cfg_height = 13'd0; cfg_surfaces = 13'd0;
      cq_ready = 1'b1; req_ready = 1'b1; rsp_done = 1'b0; op_en = 1'b1;
      @(posedge clk); #1;
      op_en = 1'b0;
      #1;
      chk("sim_first_valid", req_valid, 1);
      chk("sim_first_addr", req_addr, 64'h100);
      @(posedge clk); #1;
      rsp_done = 1'b1;
      #1;
      chk("sim_second_addr", req_addr, 64'h200);
      chk("sim_second_cube", cq_pd[0], 1);
      @(posedge clk); #1;
      rsp_done = 1'b0;
      #1;
      chk("sim_outs_kept", dut.u_outs.cnt, 1);
      chk("sim_drain_valid", req_valid, 0);
      chk("sim_drain_done", done, 0);
      rsp_done = 1'b1;
      @(posedge clk); #1;
      rsp_done = 1'b0;
      #1;
      chk("sim_done_pulse", done, 1);
      chk("sim_done_busy", busy, 1);
      @(posedge clk); #2;
      chk("sim_done_cleared", done, 0);
      chk("sim_idle_busy", busy, 0);

      // Reset mid-request with three outstanding.
      @(posedge clk); #1;
      cfg_base_addr = 64'h7000; cfg_width = 13'd63;
      req_ready = 1'b1; cq_ready = 1'b1; rsp_done = 1'b0; op_en = 1'b1;
      @(posedge clk); #1;
      op_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_outs3", dut.u_outs.cnt, 3);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", req_valid, 0);
      chk("mid_rst_outs", dut.u_outs.cnt, 0);
      @(posedge clk); #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid_next", req_valid, 0);
      rst = 1'b0;
      cfg_base_addr = 64'h3000; cfg_width = 13'd3; op_en = 1'b1;
      @(posedge clk); #1;
      op_en = 1'b0;
      #1;
      chk("restart_valid", req_valid, 1);
      chk("restart_addr", req_addr, 64'h3000);
      chk("restart_len", req_len, 3);
      do_reset();

      for (int r = 0; r < 20; r++) begin
         run_cfg({$urandom, $urandom}, 13'($urandom_range(0, 40)), 13'($urandom_range(0, 3)),
                 13'($urandom_range(0, 2)), $urandom, $urandom, 1'b1, 0,
                 n_iss, la, ll, n_done, stalls);
         chk("rnd_done_pulses", n_done, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
